// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM sharing one memory port between instruction fetch and data access.
// Sequences FETCH/DECODE/EXEC/MEM/WB, raises sticky traps and counts retired instructions.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  Opcode,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        Branch,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic        retire,
  output logic [31:0] instret,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST =
    CNT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    TRAP
  } state_t;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LW,
    CLS_SW,
    CLS_BEQ
  } cls_t;

  state_t           state;
  state_t           next_state;
  cls_t             cls;
  cls_t             dec_cls;
  logic             dec_legal;
  logic [CNT_W-1:0] cnt;
  logic             waiting;
  logic             timeout_hit;
  logic             cnt_clr;

  // Instruction class is captured in DECODE so later phases do not depend on the IR staying put.
  always_comb begin
    dec_legal = 1'b1;
    dec_cls   = CLS_R;
    case (Opcode)
      OP_R:    dec_cls = CLS_R;
      OP_I:    dec_cls = CLS_I;
      OP_LW:   dec_cls = CLS_LW;
      OP_SW:   dec_cls = CLS_SW;
      OP_BEQ:  dec_cls = CLS_BEQ;
      default: dec_legal = 1'b0;
    endcase
  end

  assign waiting     = ((state == FETCH) || (state == MEM)) && !mem_ready;
  assign timeout_hit = (MEM_TIMEOUT != 0) && waiting && (cnt == TIMEOUT_LAST);

  always_comb begin
    next_state = state;
    case (state)
      FETCH: begin
        if (mem_ready)
          next_state = DECODE;
        else if (timeout_hit)
          next_state = TRAP;
      end
      DECODE: next_state = dec_legal ? EXEC : TRAP;
      EXEC: begin
        case (cls)
          CLS_LW, CLS_SW: next_state = MEM;
          CLS_BEQ:        next_state = FETCH;
          default:        next_state = WB;
        endcase
      end
      MEM: begin
        if (mem_ready)
          next_state = (cls == CLS_LW) ? WB : FETCH;
        else if (timeout_hit)
          next_state = TRAP;
      end
      WB:      next_state = FETCH;
      TRAP:    next_state = TRAP;
      default: next_state = FETCH;
    endcase
  end

  assign cnt_clr = mem_ready ||
                   ((next_state != state) && ((next_state == FETCH) || (next_state == MEM)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= FETCH;
      cls        <= CLS_R;
      cnt        <= '0;
      instret    <= 32'd0;
      trap       <= 1'b0;
      trap_cause <= 2'b00;
    end else begin
      state <= next_state;
      if (state == DECODE)
        cls <= dec_cls;
      if (cnt_clr)
        cnt <= '0;
      else if (waiting)
        cnt <= cnt + 1'b1;
      if (retire)
        instret <= instret + 32'd1;
      // Only DECODE can trap on an illegal opcode; FETCH/MEM trap on timeout.
      if ((next_state == TRAP) && (state != TRAP)) begin
        trap       <= 1'b1;
        trap_cause <= (state == DECODE) ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;
      end
    end
  end

  // Datapath controls; qualified by reset_n so they fall the moment reset asserts.
  always_comb begin
    mem_req  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    RegWrite = 1'b0;
    MemtoReg = 1'b0;
    retire   = 1'b0;
    if (reset_n) begin
      case (state)
        FETCH: begin
          mem_req = 1'b1;
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        EXEC: begin
          ALUSrcA = 1'b1;
          case (cls)
            CLS_R: begin
              ALUSrcB = 2'b00;
              ALUOp   = 2'b10;
            end
            CLS_I: begin
              ALUSrcB = 2'b10;
              ALUOp   = 2'b10;
            end
            CLS_LW, CLS_SW: begin
              ALUSrcB = 2'b10;
              ALUOp   = 2'b00;
            end
            CLS_BEQ: begin
              ALUSrcB = 2'b00;
              ALUOp   = 2'b01;
              Branch  = 1'b1;
              retire  = 1'b1;
            end
            default: ALUSrcA = 1'b0;
          endcase
        end
        MEM: begin
          mem_req  = 1'b1;
          IorD     = 1'b1;
          MemRead  = (cls == CLS_LW);
          MemWrite = (cls == CLS_SW);
          retire   = mem_ready && (cls == CLS_SW);
        end
        WB: begin
          RegWrite = 1'b1;
          MemtoReg = (cls == CLS_LW);
          retire   = 1'b1;
        end
        default: begin
          mem_req = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction cycle expectations built from
// the phase rules (fetch waits, decode, exec, memory waits, writeback) plus trap/reset scenarios.
module tb_multicycle_controller;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // Bit positions inside the observed control vector.
  localparam int B_MREQ = 17;
  localparam int B_IORD = 16;
  localparam int B_MRD  = 15;
  localparam int B_MWR  = 14;
  localparam int B_IRW  = 13;
  localparam int B_PCW  = 12;
  localparam int B_BR   = 11;
  localparam int B_ASA  = 10;
  localparam int B_RW   = 5;
  localparam int B_M2R  = 4;
  localparam int B_RET  = 3;
  localparam int B_TRAP = 2;

  typedef logic [17:0] vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  Opcode = 7'd0;
  logic        mem_ready = 1'b0;
  logic        mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, Branch, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOp;
  logic        RegWrite, MemtoReg, retire;
  logic [31:0] instret;
  logic        trap;
  logic [1:0]  trap_cause;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_instret = 32'd0;
  vec_t        exp_q[$];
  logic        rdy_q[$];
  logic [6:0]  op_q[$];

  multicycle_controller #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .Opcode(Opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .retire(retire), .instret(instret), .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic vec_t observe();
    return {mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, Branch, ALUSrcA,
            ALUSrcB, ALUOp, RegWrite, MemtoReg, retire, trap, trap_cause};
  endfunction

  function automatic vec_t fetch_vec(input logic done);
    vec_t v = '0;
    v[B_MREQ] = 1'b1;
    v[B_MRD]  = 1'b1;
    v[9:8]    = 2'b01;
    v[B_IRW]  = done;
    v[B_PCW]  = done;
    return v;
  endfunction

  function automatic vec_t exec_vec(input logic [6:0] op);
    vec_t v = '0;
    v[B_ASA] = 1'b1;
    if (op == OP_R) begin
      v[7:6] = 2'b10;
    end else if (op == OP_I) begin
      v[9:8] = 2'b10;
      v[7:6] = 2'b10;
    end else if (op == OP_BEQ) begin
      v[7:6]   = 2'b01;
      v[B_BR]  = 1'b1;
      v[B_RET] = 1'b1;
    end else begin
      v[9:8] = 2'b10;
    end
    return v;
  endfunction

  function automatic vec_t mem_vec(input logic is_lw, input logic done);
    vec_t v = '0;
    v[B_MREQ] = 1'b1;
    v[B_IORD] = 1'b1;
    v[B_MRD]  = is_lw;
    v[B_MWR]  = !is_lw;
    v[B_RET]  = done && !is_lw;
    return v;
  endfunction

  function automatic vec_t wb_vec(input logic is_lw);
    vec_t v = '0;
    v[B_RW]  = 1'b1;
    v[B_M2R] = is_lw;
    v[B_RET] = 1'b1;
    return v;
  endfunction

  function automatic vec_t trap_vec(input logic [1:0] cause);
    vec_t v = '0;
    v[B_TRAP] = 1'b1;
    v[1:0]    = cause;
    return v;
  endfunction

  // Reference expansion of one instruction into its per-cycle control pattern.
  function automatic void build_instr(input logic [6:0] op, input int fw, input int mw);
    logic is_mem = (op == OP_LW) || (op == OP_SW);
    logic has_wb = (op == OP_R) || (op == OP_I) || (op == OP_LW);
    exp_q.delete();
    rdy_q.delete();
    op_q.delete();
    for (int i = 0; i < fw; i++) begin
      exp_q.push_back(fetch_vec(1'b0)); rdy_q.push_back(1'b0); op_q.push_back(7'($urandom));
    end
    exp_q.push_back(fetch_vec(1'b1)); rdy_q.push_back(1'b1); op_q.push_back(7'($urandom));
    exp_q.push_back('0); rdy_q.push_back(1'($urandom)); op_q.push_back(op);
    exp_q.push_back(exec_vec(op)); rdy_q.push_back(1'($urandom)); op_q.push_back(op);
    if (is_mem) begin
      for (int i = 0; i < mw; i++) begin
        exp_q.push_back(mem_vec(op == OP_LW, 1'b0)); rdy_q.push_back(1'b0); op_q.push_back(op);
      end
      exp_q.push_back(mem_vec(op == OP_LW, 1'b1)); rdy_q.push_back(1'b1); op_q.push_back(op);
    end
    if (has_wb) begin
      exp_q.push_back(wb_vec(op == OP_LW)); rdy_q.push_back(1'($urandom)); op_q.push_back(op);
    end
  endfunction

  task automatic do_reset();
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n     = 1'b1;
    exp_instret = 32'd0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    n_checks++;
    if (observe() !== vec_t'(0)) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", observe(), vec_t'(0));
    end
    n_checks++;
    if (instret !== 32'd0) begin
      n_fail++; $display("FAIL reset_instret: got %h expected 0", instret);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (observe() !== fetch_vec(1'b0)) begin
      n_fail++; $display("FAIL reset_fetch: got %h expected %h", observe(), fetch_vec(1'b0));
    end
    $display("reset: outputs idle, FETCH after release");
    @(negedge clk);
  endtask

  task automatic test_rtype();
    build_instr(OP_R, 0, 0);
    foreach (exp_q[i]) begin
      mem_ready = rdy_q[i]; Opcode = op_q[i]; #1;
      n_checks++;
      if (observe() !== exp_q[i]) begin
        n_fail++; $display("FAIL rtype cycle %0d: got %h expected %h", i + 1, observe(), exp_q[i]);
      end
      @(negedge clk);
    end
    exp_instret++;
    n_checks++;
    if (instret !== exp_instret) begin
      n_fail++; $display("FAIL rtype_instret: got %0d expected %0d", instret, exp_instret);
    end
    $display("rtype: %0d cycles, instret=%0d", exp_q.size(), instret);
  endtask

  task automatic test_lw_wait();
    build_instr(OP_LW, 0, 3);
    foreach (exp_q[i]) begin
      mem_ready = rdy_q[i]; Opcode = op_q[i]; #1;
      n_checks++;
      if (observe() !== exp_q[i]) begin
        n_fail++; $display("FAIL lw_wait cycle %0d: got %h expected %h", i + 1, observe(), exp_q[i]);
      end
      @(negedge clk);
    end
    exp_instret++;
    n_checks++;
    if (instret !== exp_instret) begin
      n_fail++; $display("FAIL lw_instret: got %0d expected %0d", instret, exp_instret);
    end
    $display("lw with 3 wait cycles: %0d cycles, instret=%0d", exp_q.size(), instret);
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [2];
    ops[0] = OP_SW;
    ops[1] = OP_BEQ;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      build_instr(ops[k], 0, 0);
      foreach (exp_q[i]) begin
        mem_ready = rdy_q[i]; Opcode = op_q[i]; #1;
        n_checks++;
        if (observe() !== exp_q[i]) begin
          n_fail++;
          $display("FAIL b2b op %b cycle %0d: got %h expected %h", ops[k], i + 1, observe(), exp_q[i]);
        end
        @(negedge clk);
      end
      exp_instret++;
      $display("b2b: op %b in %0d cycles", ops[k], exp_q.size());
    end
    n_checks++;
    if (instret !== 32'd2) begin
      n_fail++; $display("FAIL b2b_instret: got %0d expected 2", instret);
    end
  endtask

  task automatic test_reset_mid_mem();
    build_instr(OP_SW, 0, 5);
    for (int i = 0; i < 5; i++) begin
      mem_ready = rdy_q[i]; Opcode = op_q[i]; #1;
      n_checks++;
      if (observe() !== exp_q[i]) begin
        n_fail++; $display("FAIL mid_mem cycle %0d: got %h expected %h", i + 1, observe(), exp_q[i]);
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if (MemWrite !== 1'b1) begin
      n_fail++; $display("FAIL mid_mem_write_before: got %b expected 1", MemWrite);
    end
    #1;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (observe() !== vec_t'(0)) begin
      n_fail++; $display("FAIL mid_mem_async_drop: got %h expected %h", observe(), vec_t'(0));
    end
    @(negedge clk);
    @(negedge clk);
    reset_n     = 1'b1;
    exp_instret = 32'd0;
    n_checks++;
    if (instret !== 32'd0) begin
      n_fail++; $display("FAIL mid_mem_instret: got %0d expected 0", instret);
    end
    mem_ready = 1'b0; Opcode = 7'($urandom); #1;
    n_checks++;
    if (observe() !== fetch_vec(1'b0)) begin
      n_fail++; $display("FAIL mid_mem_refetch: got %h expected %h", observe(), fetch_vec(1'b0));
    end
    $display("reset during sw MEM: outputs dropped, restarted in FETCH");
    @(negedge clk);
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.instret = 32'hFFFF_FFFF;
    #1;
    release dut.instret;
    exp_instret = 32'hFFFF_FFFF;
    #1;
    n_checks++;
    if (instret !== exp_instret) begin
      n_fail++; $display("FAIL wrap_preload: got %h expected %h", instret, exp_instret);
    end
    build_instr(OP_BEQ, 1, 0);
    foreach (exp_q[i]) begin
      mem_ready = rdy_q[i]; Opcode = op_q[i]; #1;
      n_checks++;
      if (observe() !== exp_q[i]) begin
        n_fail++; $display("FAIL wrap cycle %0d: got %h expected %h", i + 1, observe(), exp_q[i]);
      end
      @(negedge clk);
    end
    exp_instret++;
    n_checks++;
    if (instret !== exp_instret) begin
      n_fail++; $display("FAIL wrap_instret: got %h expected %h", instret, exp_instret);
    end
    $display("wrap: instret after retire = %h", instret);
  endtask

  task automatic test_random();
    logic [6:0] legal [5];
    legal[0] = OP_R; legal[1] = OP_I; legal[2] = OP_LW; legal[3] = OP_SW; legal[4] = OP_BEQ;
    for (int n = 0; n < 24; n++) begin
      logic [6:0] op = legal[$urandom_range(0, 4)];
      int fw = int'($urandom_range(0, 5));
      int mw = int'($urandom_range(0, 5));
      build_instr(op, fw, mw);
      foreach (exp_q[i]) begin
        mem_ready = rdy_q[i]; Opcode = op_q[i]; #1;
        n_checks++;
        if (observe() !== exp_q[i]) begin
          n_fail++;
          $display("FAIL random #%0d op %b cycle %0d: got %h expected %h", n, op, i + 1, observe(), exp_q[i]);
        end
        @(negedge clk);
      end
      exp_instret++;
      n_checks++;
      if (instret !== exp_instret) begin
        n_fail++; $display("FAIL random_instret #%0d: got %0d expected %0d", n, instret, exp_instret);
      end
      $display("random #%0d: op %b fw=%0d mw=%0d cycles=%0d instret=%0d", n, op, fw, mw, exp_q.size(), instret);
    end
  endtask

  task automatic test_illegal();
    mem_ready = 1'b1; Opcode = 7'($urandom); #1;
    n_checks++;
    if (observe() !== fetch_vec(1'b1)) begin
      n_fail++; $display("FAIL illegal_fetch: got %h expected %h", observe(), fetch_vec(1'b1));
    end
    @(negedge clk);
    mem_ready = 1'($urandom); Opcode = 7'h7F; #1;
    n_checks++;
    if (observe() !== vec_t'(0)) begin
      n_fail++; $display("FAIL illegal_decode: got %h expected %h", observe(), vec_t'(0));
    end
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'($urandom); #1;
      n_checks++;
      if (observe() !== trap_vec(2'b01)) begin
        n_fail++; $display("FAIL illegal_trap cycle %0d: got %h expected %h", i, observe(), trap_vec(2'b01));
      end
      @(negedge clk);
    end
    do_reset();
    #1;
    n_checks++;
    if (observe() !== fetch_vec(1'b0)) begin
      n_fail++; $display("FAIL illegal_recover: got %h expected %h", observe(), fetch_vec(1'b0));
    end
    $display("illegal opcode 1111111: trapped with cause 01, cleared by reset");
    @(negedge clk);
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      mem_ready = 1'b0; Opcode = 7'($urandom); #1;
      n_checks++;
      if (observe() !== fetch_vec(1'b0)) begin
        n_fail++; $display("FAIL timeout_wait cycle %0d: got %h expected %h", i + 1, observe(), fetch_vec(1'b0));
      end
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 0) ? 1'b0 : 1'($urandom); #1;
      n_checks++;
      if (observe() !== trap_vec(2'b10)) begin
        n_fail++; $display("FAIL timeout_trap cycle %0d: got %h expected %h", i, observe(), trap_vec(2'b10));
      end
      @(negedge clk);
    end
    $display("fetch timeout: mem_req held 16 cycles then trap cause 10");
    do_reset();
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_back_to_back();
    test_reset_mid_mem();
    test_wrap();
    test_random();
    test_illegal();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
